item_catcher: RTL and testbench
===============================

# item_catcher

Responder side of the falling-item interface. It samples the falling item's position and color each `fall_clk` and compares them against the player platform and the current stack top. It decides once per item whether the item is caught (stacked) or missed, and tracks stack contents, score, misses and game-over for the renderer. The `collision` pulse it produces is the return signal for the falling-item generator.

## Interface
- `ITEM_H`, 20: item height in pixels; also the height of one stacked layer.
- `BASE_Y`, 400: y coordinate of the stack floor (top surface of an empty stack).
- `CATCH_W`, 24: maximum |item_x − player_x| for a catch, inclusive.
- `DEPTH`, 8: stack capacity in layers.
- `MAX_MISS`, 3: number of misses that ends the game.

- `fall_clk`  in  1  block clock; the same clock that advances the falling item.
- `rst`  in  1  asynchronous, active-high reset.
- `pause`  in  1  when high, freezes all state; no decisions are made.
- `item_x`  in  10  falling item x position.
- `item_y`  in  10  falling item y position (top edge).
- `item_color`  in  2  falling item color.
- `player_x`  in  10  platform x position.
- `collision`  out  1  one-cycle pulse when an item is caught.
- `miss`  out  1  one-cycle pulse when an item is missed.
- `height`  out  4  number of stacked layers, 0..DEPTH−1.
- `stack_colors`  out  2*DEPTH  layer i color at bits [2i+1:2i]; layer 0 is the bottom.
- `score`  out  8  saturating score.
- `game_over`  out  1  high while in the OVER state.

## Operation
States:
- **TRACK**: evaluates the current item.
- **LOCKOUT**: ignores the current item after a decision.
- **OVER**: terminal until `rst`.

Reset values:
- State is TRACK.
- `height`, `stack_colors`, `score`, `collision`, `miss`, `game_over` are all 0.
- Internal `miss_cnt` is 0 and `prev_y` is 0.

Arithmetic, all 11-bit unsigned:
- `top = BASE_Y − height*ITEM_H`.
- `bottom = item_y + ITEM_H`.
- `dx = |item_x − player_x|`.

TRACK, when `pause` = 0 and `bottom >= top`:
- **Catch** (`dx <= CATCH_W`):
  - Write `item_color` into layer `height`.
  - Increment `height`.
  - Add 1 to `score`, plus 1 more if `height` > 0 and `item_color` equals the color of layer `height−1`.
  - Pulse `collision`.
  - Go to LOCKOUT.
- **Miss** (`dx > CATCH_W`):
  - Pulse `miss`.
  - Increment `miss_cnt`.
  - If `miss_cnt` reaches MAX_MISS, go to OVER; otherwise go to LOCKOUT.
- If `bottom < top`, no action.

Full stack:
- If a catch would make `height` equal DEPTH, the tower is complete.
- The tower-complete update replaces the normal layer write and height increment: `height` and `stack_colors` are cleared to 0.
- `score` gains 1 + 10 (plus the color bonus if it applies).
- `collision` still pulses.

Score:
- Saturates at 255. It never wraps.

LOCKOUT:
- Leave for TRACK on the first unpaused cycle where `item_y < prev_y`, i.e. a respawn is detected.
- The new item is not evaluated in that same cycle; evaluation starts on the next cycle.

`prev_y`:
- Updated to `item_y` every unpaused cycle, in all states except OVER.

OVER:
- `game_over` = 1.
- All other outputs hold their values; pulses stay 0.
- Inputs are ignored.

Pause:
- When `pause` = 1, no register changes, except that the pulses drop to 0.

## Timing
Decisions:
- Inputs are sampled at the rising edge of `fall_clk`.
- Decisions and all register updates take effect at that same edge.
- `collision` and `miss` are high for exactly one `fall_clk` cycle following the deciding edge.

Per-item and simultaneity rules:
- At most one decision per item.
- `collision` and `miss` are never high together.

Reset:
- `rst` asserted at any time, including during a pulse or in OVER, forces all reset values immediately (asynchronous).
- Operation resumes at the first `fall_clk` edge after `rst` deasserts.

Geometry limit:
- With DEPTH = 8 and ITEM_H = 20, `top` is at least 260, so no underflow occurs.
- Parameter sets must keep `DEPTH*ITEM_H < BASE_Y`.

## Test plan
1. **Basic catch**
   - Stimulus: `height` = 0, `player_x` = 110, `item_x` = 100, `item_y` stepping 376, 378, 380.
   - Required: no action at 378 (`bottom` = 398); catch at 380.
   - Required: `collision` pulse, `height` = 1, `score` = 1, layer 0 = `item_color`.
2. **Color bonus and lockout**
   - Stimulus: `item_y` continues 382..400 without a respawn.
   - Required: no further pulses.
   - Stimulus: respawn to `item_y` = 0, same color, caught at `item_y` = 360 (`top` = 380).
   - Required: `height` = 2, `score` = 3.
3. **Miss to game over**
   - Stimulus: `dx` = 25 at the crossing, repeated for three items with respawns in between.
   - Required: three `miss` pulses; `game_over` = 1 after the third.
   - Required: a later aligned item produces no `collision`.
4. **Tower complete**
   - Stimulus: fill 7 layers, then catch an 8th.
   - Required: `height` = 0, `stack_colors` = 0, `score` increases by 11 (12 if the color matches).
5. **Pause**
   - Stimulus: hold `pause` = 1 while `bottom` ≥ `top`, aligned.
   - Required: no pulse and no state change.
   - Stimulus: release `pause`.
   - Required: catch on the next edge.
6. **Reset and score saturation**
   - Stimulus: `rst` pulse in OVER and mid-pulse.
   - Required: all outputs 0 immediately.
   - Stimulus: preload `score` at 254, then catch with the color bonus.
   - Required: `score` = 255.

Source files
------------

// File: rtl/item_catcher.sv
// item_catcher: decides once per falling item whether it lands on the stack
// (catch) or beside the platform (miss). It keeps the tower contents, the
// saturating score and the miss count, and latches game over after MAX_MISS misses.
module item_catcher #(
    parameter int ITEM_H   = 20,
    parameter int BASE_Y   = 400,
    parameter int CATCH_W  = 24,
    parameter int DEPTH    = 8,
    parameter int MAX_MISS = 3
) (
    input  logic               fall_clk,
    input  logic               rst,
    input  logic               pause,
    input  logic [9:0]         item_x,
    input  logic [9:0]         item_y,
    input  logic [1:0]         item_color,
    input  logic [9:0]         player_x,
    output logic               collision,
    output logic               miss,
    output logic [3:0]         height,
    output logic [2*DEPTH-1:0] stack_colors,
    output logic [7:0]         score,
    output logic               game_over
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MISS_W = $clog2(MAX_MISS + 1);

    localparam logic [10:0]       ITEM_H_W   = 11'(ITEM_H);
    localparam logic [10:0]       BASE_Y_W   = 11'(BASE_Y);
    localparam logic [10:0]       CATCH_W_W  = 11'(CATCH_W);
    localparam logic [3:0]        LAST_LAYER = 4'(DEPTH - 1);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(MAX_MISS);

    typedef enum logic [1:0] {
        ST_TRACK,
        ST_LOCKOUT,
        ST_OVER
    } state_t;

    state_t                 state_q, state_d;
    logic [DEPTH-1:0][1:0]  layers_q, layers_d;
    logic [3:0]             height_q, height_d;
    logic [7:0]             score_q, score_d;
    logic [MISS_W-1:0]      miss_cnt_q, miss_cnt_d;
    logic [9:0]             prev_y_q, prev_y_d;
    logic                   collision_q, collision_d;
    logic                   miss_q, miss_d;

    logic [10:0]            top;
    logic [10:0]            bottom;
    logic [10:0]            ext_item_x;
    logic [10:0]            ext_player_x;
    logic [10:0]            dx;
    logic [IDX_W-1:0]       wr_idx;
    logic [IDX_W-1:0]       below_idx;
    logic                   reached;
    logic                   aligned;
    logic                   bonus;
    logic                   tower_done;
    logic [8:0]             score_inc;
    logic [8:0]             score_sum;
    logic [MISS_W-1:0]      miss_next;

    // Geometry of the item against the stack top, and the would-be score gain of a catch.
    always_comb begin
        ext_item_x   = {1'b0, item_x};
        ext_player_x = {1'b0, player_x};
        top          = BASE_Y_W - ({7'd0, height_q} * ITEM_H_W);
        bottom       = {1'b0, item_y} + ITEM_H_W;
        dx           = (ext_item_x >= ext_player_x) ? (ext_item_x - ext_player_x)
                                                    : (ext_player_x - ext_item_x);
        reached      = (bottom >= top);
        aligned      = (dx <= CATCH_W_W);
        wr_idx       = height_q[IDX_W-1:0];
        below_idx    = wr_idx - IDX_W'(1);
        bonus        = (height_q != 4'd0) && (item_color == layers_q[below_idx]);
        tower_done   = (height_q == LAST_LAYER);
        score_inc    = 9'd1 + {8'd0, bonus} + (tower_done ? 9'd10 : 9'd0);
        score_sum    = {1'b0, score_q} + score_inc;
        miss_next    = miss_cnt_q + MISS_W'(1);
    end

    // Next-state logic: one decision per item, lockout until a respawn, pause freezes everything.
    always_comb begin
        state_d     = state_q;
        layers_d    = layers_q;
        height_d    = height_q;
        score_d     = score_q;
        miss_cnt_d  = miss_cnt_q;
        prev_y_d    = prev_y_q;
        collision_d = 1'b0;
        miss_d      = 1'b0;

        if (!pause && (state_q != ST_OVER)) begin
            prev_y_d = item_y;
            case (state_q)
                ST_TRACK: begin
                    if (reached) begin
                        if (aligned) begin
                            collision_d = 1'b1;
                            state_d     = ST_LOCKOUT;
                            score_d     = score_sum[8] ? 8'hFF : score_sum[7:0];
                            if (tower_done) begin
                                layers_d = '0;
                                height_d = 4'd0;
                            end else begin
                                layers_d[wr_idx] = item_color;
                                height_d         = height_q + 4'd1;
                            end
                        end else begin
                            miss_d     = 1'b1;
                            miss_cnt_d = miss_next;
                            if (miss_next == MISS_LIMIT) begin
                                state_d = ST_OVER;
                            end else begin
                                state_d = ST_LOCKOUT;
                            end
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (item_y < prev_y_q) begin
                        state_d = ST_TRACK;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge fall_clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_TRACK;
            layers_q    <= '0;
            height_q    <= 4'd0;
            score_q     <= 8'd0;
            miss_cnt_q  <= '0;
            prev_y_q    <= 10'd0;
            collision_q <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            layers_q    <= layers_d;
            height_q    <= height_d;
            score_q     <= score_d;
            miss_cnt_q  <= miss_cnt_d;
            prev_y_q    <= prev_y_d;
            collision_q <= collision_d;
            miss_q      <= miss_d;
        end
    end

    assign collision    = collision_q;
    assign miss         = miss_q;
    assign height       = height_q;
    assign stack_colors = layers_q;
    assign score        = score_q;
    assign game_over    = (state_q == ST_OVER);

endmodule

// File: tb/tb_item_catcher.sv
// tb_item_catcher: directed and randomized item sequences checked against a
// behavioural model of the catch/miss/tower/score rules.
module tb_item_catcher;

    logic        fall_clk = 1'b0;
    logic        rst;
    logic        pause;
    logic [9:0]  item_x;
    logic [9:0]  item_y;
    logic [1:0]  item_color;
    logic [9:0]  player_x;
    logic        collision;
    logic        miss;
    logic [3:0]  height;
    logic [15:0] stack_colors;
    logic [7:0]  score;
    logic        game_over;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int m_stack[$];
    int m_score;
    int m_misses;
    bit m_over;
    bit m_locked;
    int m_prev_y;
    bit m_col;
    bit m_miss;

    localparam int PX = 300;

    item_catcher dut (
        .fall_clk     (fall_clk),
        .rst          (rst),
        .pause        (pause),
        .item_x       (item_x),
        .item_y       (item_y),
        .item_color   (item_color),
        .player_x     (player_x),
        .collision    (collision),
        .miss         (miss),
        .height       (height),
        .stack_colors (stack_colors),
        .score        (score),
        .game_over    (game_over)
    );

    // Free-running block clock.
    always #5 fall_clk = ~fall_clk;

    function automatic void model_reset();
        m_stack.delete();
        m_score  = 0;
        m_misses = 0;
        m_over   = 1'b0;
        m_locked = 1'b0;
        m_prev_y = 0;
        m_col    = 1'b0;
        m_miss   = 1'b0;
    endfunction

    function automatic void model_step(input bit p, input int ix, input int iy,
                                       input int col, input int px);
        int top;
        int dx;
        int inc;
        m_col  = 1'b0;
        m_miss = 1'b0;
        if (m_over || p) return;
        if (!m_locked) begin
            top = 400 - 20 * m_stack.size();
            if (iy + 20 >= top) begin
                dx = (ix > px) ? ix - px : px - ix;
                if (dx <= 24) begin
                    inc = 1;
                    if (m_stack.size() > 0 && m_stack[$] == col) inc++;
                    if (m_stack.size() == 7) begin
                        m_stack.delete();
                        inc += 10;
                    end else begin
                        m_stack.push_back(col);
                    end
                    m_score  = (m_score + inc > 255) ? 255 : m_score + inc;
                    m_col    = 1'b1;
                    m_locked = 1'b1;
                end else begin
                    m_miss = 1'b1;
                    m_misses++;
                    if (m_misses >= 3) m_over = 1'b1;
                    else m_locked = 1'b1;
                end
            end
        end else if (iy < m_prev_y) begin
            m_locked = 1'b0;
        end
        m_prev_y = iy;
    endfunction

    function automatic logic [15:0] model_stack();
        logic [15:0] v;
        v = '0;
        foreach (m_stack[i]) v[2*i +: 2] = 2'(m_stack[i]);
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, " collision"},    32'(collision),    32'(m_col));
        check({tag, " miss"},         32'(miss),         32'(m_miss));
        check({tag, " height"},       32'(height),       32'(m_stack.size()));
        check({tag, " stack_colors"}, 32'(stack_colors), 32'(model_stack()));
        check({tag, " score"},        32'(score),        32'(m_score));
        check({tag, " game_over"},    32'(game_over),    32'(m_over));
    endtask

    task automatic apply_stimulus(input string tag, input bit p, input int ix,
                                  input int iy, input int col, input int px);
        pause      = p;
        item_x     = 10'(ix);
        item_y     = 10'(iy);
        item_color = 2'(col);
        player_x   = 10'(px);
        @(posedge fall_clk);
        model_step(p, ix, iy, col, px);
        #1;
        check_output(tag);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock.
    task automatic do_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_output(tag);
        @(negedge fall_clk);
        rst = 1'b0;
    endtask

    task automatic catch_item(input string tag, input int col, input int dx);
        apply_stimulus({tag, " respawn"}, 1'b0, PX + dx, 0, col, PX);
        apply_stimulus({tag, " land"},    1'b0, PX + dx, 395, col, PX);
    endtask

    initial begin
        int s0;
        int y;
        int col;
        int dx;

        rst = 1'b1; pause = 1'b0; item_x = '0; item_y = '0; item_color = '0; player_x = '0;
        model_reset();
        #1;
        check_output("reset");
        @(negedge fall_clk);
        @(negedge fall_clk);
        rst = 1'b0;

        $display("[TB] basic catch");
        apply_stimulus("t1 y376", 1'b0, 100, 376, 2, 110);
        apply_stimulus("t1 y378", 1'b0, 100, 378, 2, 110);
        apply_stimulus("t1 y380", 1'b0, 100, 380, 2, 110);
        check("t1 collision", 32'(collision), 32'd1);
        check("t1 height", 32'(height), 32'd1);
        check("t1 score", 32'(score), 32'd1);
        check("t1 layer0", 32'(stack_colors[1:0]), 32'd2);

        $display("[TB] lockout and color bonus");
        for (int yy = 382; yy <= 400; yy += 2)
            apply_stimulus("t2 lockout", 1'b0, 100, yy, 2, 110);
        for (int yy = 0; yy <= 360; yy += 20)
            apply_stimulus("t2 fall", 1'b0, 100, yy, 2, 110);
        check("t2 height", 32'(height), 32'd2);
        check("t2 score", 32'(score), 32'd3);

        $display("[TB] tower complete");
        for (int k = 0; k < 5; k++)
            catch_item("t4 fill", int'($urandom_range(0, 3)), int'($urandom_range(0, 48)) - 24);
        s0 = m_score;
        catch_item("t4 tower", m_stack[$], -24);
        check("t4 height", 32'(height), 32'd0);
        check("t4 stack", 32'(stack_colors), 32'd0);
        check("t4 score", 32'(score), 32'(s0 + 12));

        $display("[TB] pause");
        apply_stimulus("t5 respawn", 1'b0, PX, 0, 1, PX);
        for (int k = 0; k < 3; k++)
            apply_stimulus("t5 paused", 1'b1, PX, 395, 1, PX);
        apply_stimulus("t5 release", 1'b0, PX, 395, 1, PX);
        check("t5 collision", 32'(collision), 32'd1);

        $display("[TB] random items");
        for (int it = 0; it < 15; it++) begin
            col = int'($urandom_range(0, 3));
            dx  = int'($urandom_range(0, 48)) - 24;
            y   = int'($urandom_range(0, 40));
            apply_stimulus("rand respawn", ($urandom_range(0, 5) == 0), PX + dx, y, col, PX);
            while (y < 440) begin
                y += int'($urandom_range(1, 15));
                apply_stimulus("rand fall", ($urandom_range(0, 5) == 0), PX + dx, y, col, PX);
            end
        end

        $display("[TB] misses to game over");
        for (int k = 0; k < 3; k++) begin
            dx = (k == 1) ? -25 : 25;
            apply_stimulus("t3 respawn", 1'b0, PX + dx, 0, 0, PX);
            apply_stimulus("t3 cross", 1'b0, PX + dx, 395, 0, PX);
            check("t3 miss pulse", 32'(miss), 32'd1);
        end
        check("t3 game_over", 32'(game_over), 32'd1);
        apply_stimulus("t3 over respawn", 1'b0, PX, 0, 0, PX);
        apply_stimulus("t3 over aligned", 1'b0, PX, 395, 0, PX);
        check("t3 no collision", 32'(collision), 32'd0);
        do_reset("t6 reset in over");

        $display("[TB] reset mid-pulse");
        catch_item("t6 catch", 3, 0);
        do_reset("t6 reset mid pulse");

        $display("[TB] score saturation");
        for (int t = 0; t < 10; t++)
            for (int k = 0; k < 8; k++)
                catch_item("t6 towers", t % 4, int'($urandom_range(0, 48)) - 24);
        check("t6 score 250", 32'(score), 32'd250);
        catch_item("t6 a", 1, 3);
        catch_item("t6 b", 1, -3);
        catch_item("t6 c", 2, 0);
        check("t6 score 254", 32'(score), 32'd254);
        catch_item("t6 sat", 2, 10);
        check("t6 score 255", 32'(score), 32'd255);
        catch_item("t6 hold", 2, -10);
        check("t6 score held", 32'(score), 32'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
